// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for serial_adder.
// Holds the FSM state encoding and the bit-counter width function.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SA_DEFAULT_WIDTH = 8;

  // Counter width: wide enough to hold WIDTH itself.
  function automatic int sa_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/adder.sv
// 1-bit full adder used for the bit-serial add.
// Purely combinational, no state.
module adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per cycle, result after WIDTH run cycles, held until out_ready.
// Optional SERIAL_ADDER_SUB_EN adds a sub input selecting a - b (c_out=1 means no borrow).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = sa_cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_c_out;
  logic [CW-1:0]    r_cnt;
  logic             w_sum;
  logic             w_cout;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_b_in;
  logic             w_c_in;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_in = sub ? ~b : b;
  assign w_c_in = sub ? 1'b1 : c_in;
`else
  assign w_b_in = b;
  assign w_c_in = c_in;
`endif

  adder u_adder (
    .a     (r_a[0]),
    .b     (r_b[0]),
    .c_in  (r_carry),
    .sum   (w_sum),
    .c_out (w_cout)
  );

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sum bits refill r_a from the top as it drains, so r_a ends up holding the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_c_out <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_in;
      r_carry <= w_c_in;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= {w_sum, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_res   <= {w_sum, r_a[WIDTH-1:1]};
        r_c_out <= w_cout;
      end
    end
  end

  assign sum   = r_res;
  assign c_out = r_c_out;

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder (WIDTH=8); sub vectors run when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One transaction: checks latency, result, stall hold, and return to IDLE.
  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input logic [W-1:0] es, input logic ec, input int stall);
    int n;
    @(negedge clk);
    a = ta; b = tb; c_in = tc; in_valid = 1'b1; out_ready = 1'b0;
    chk({tag, "_in_ready"}, in_ready, 1);
    n = 0;
    do begin
      @(posedge clk); n++; #1;
      in_valid = 1'b0; a = ~ta; b = 8'h5A; c_in = ~tc;
    end while (!out_valid && n < 40);
    chk({tag, "_latency"}, n, W + 1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, c_out, ec);
    for (int i = 0; i < stall; i++) begin
      in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      chk({tag, "_stall_vld"}, out_valid, 1);
      chk({tag, "_stall_sum"}, sum, es);
      chk({tag, "_stall_cout"}, c_out, ec);
      chk({tag, "_stall_rdy"}, in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drained"}, out_valid, 0);
    chk({tag, "_idle"}, in_ready, 1);
    chk({tag, "_held"}, {c_out, sum}, {ec, es});
  endtask

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vc;
    logic [W-1:0] vs;
    logic         vco;
  } vec_t;

  vec_t bb[4];

  initial begin
    int idx_in, idx_out, last_cyc;
    bit acc;

    bb[0] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    bb[1] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    bb[2] = '{8'h0F, 8'h01, 1'b1, 8'h11, 1'b0};
    bb[3] = '{8'hC3, 8'h3C, 1'b1, 8'h00, 1'b1};

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", c_out, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);

    do_op("add35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 0);
    do_op("wrap_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
    do_op("ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 5);

    // Reset during RUN bit 4
    @(negedge clk);
    a = 8'hAA; b = 8'h55; c_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", c_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("abort_in_ready", in_ready, 1);
    repeat (W + 2) @(posedge clk);
    #1 chk("abort_no_result", out_valid, 0);
    do_op("post_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    do_op("sub_10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, 0);
    do_op("sub_01_02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 0);
    sub = 1'b0;
`endif

    // Back-to-back with in_valid and out_ready held high
    idx_in = 0; idx_out = 0; last_cyc = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && idx_out < 4; cyc++) begin
      @(negedge clk);
      if (idx_in < 4) begin
        a = bb[idx_in].va; b = bb[idx_in].vb; c_in = bb[idx_in].vc; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      acc = in_ready && in_valid;
      if (out_valid) begin
        chk($sformatf("b2b%0d_res", idx_out), {c_out, sum}, {bb[idx_out].vco, bb[idx_out].vs});
        if (last_cyc >= 0) chk($sformatf("b2b%0d_interval", idx_out), cyc - last_cyc, W + 2);
        last_cyc = cyc;
        idx_out++;
      end
      @(posedge clk);
      if (acc) idx_in++;
    end
    chk("b2b_count", idx_out, 4);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
